// File: rtl/pitch_pkg.sv
// Shared types for the pitch-shift overlap-add back end.
package pitch_pkg;

  localparam int SLOT_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    WAIT_STITCH,
    READY,
    WAIT_EMIT
  } ola_state_t;

endpackage

// File: rtl/ola_watchdog.sv
// Cycle watchdog: counts while run is high and raises expired on the TIMEOUT-th cycle.
module ola_watchdog #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;

  // The count for a wait starts at zero in its first cycle, so expiry fires on cycle TIMEOUT.
  assign expired = run && !clear && (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ola_window_scheduler.sv
// Overlap-add scheduler: hands each IFFT window to the stitcher, then its finished quarter to the emitter.
module ola_window_scheduler
  import pitch_pkg::*;
#(
  parameter int NUM_SLOTS     = 4,
  parameter int PRIME_WINDOWS = 3,
  parameter int TIMEOUT       = 65535,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              frame_valid,
  output logic              frame_ready,
  output logic              stitch_go,
  output logic [SLOT_W-1:0] stitch_slot,
  input  logic              stitch_done,
  input  logic              emit_req,
  output logic              emit_go,
  output logic [SLOT_W-1:0] emit_slot,
  input  logic              emit_done,
  output logic [CNT_W-1:0]  frames_out,
  output logic [CNT_W-1:0]  underruns,
  output logic              fault
);

  localparam int PW = (PRIME_WINDOWS < 1) ? 1 : $clog2(PRIME_WINDOWS + 1);
  localparam logic [PW-1:0]     PRIME_LAST = PW'(PRIME_WINDOWS);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NUM_SLOTS - 1);

  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
    return (s == SLOT_LAST) ? '0 : s + 1'b1;
  endfunction

  ola_state_t        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [PW-1:0]     prime_q, prime_d;
  logic [CNT_W-1:0]  frames_q, frames_d;
  logic [CNT_W-1:0]  under_q, under_d;
  logic              fault_q, fault_d;
  logic              stitch_go_q, stitch_go_d;
  logic              emit_go_q, emit_go_d;
  logic              frame_ready_q, frame_ready_d;
  logic              emit_req_q;
  logic              primed;
  logic              in_wait;
  logic              wd_expired;

  assign primed  = (prime_q == PRIME_LAST);
  assign in_wait = (state_q == WAIT_STITCH) || (state_q == WAIT_EMIT);

  ola_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (!in_wait),
    .run    (in_wait),
    .expired(wd_expired)
  );

  always_comb begin
    // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
    state_d       = state_q;
    slot_d        = slot_q;
    prime_d       = prime_q;
    frames_d      = frames_q;
    under_d       = under_q;
    fault_d       = fault_q;
    stitch_go_d   = 1'b0;
    emit_go_d     = 1'b0;
    frame_ready_d = 1'b0;

    if (emit_req && !emit_req_q && (state_q != READY) && primed && (under_q != '1)) begin
      under_d = under_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (enable && !fault_q) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        // frame_valid is still high in the frame_ready cycle; that window is already consumed.
        if (!enable) begin
          state_d = IDLE;
        end else if (frame_valid && !frame_ready_q) begin
          stitch_go_d = 1'b1;
          state_d     = WAIT_STITCH;
        end
      end
      WAIT_STITCH: begin
        if (wd_expired) begin
          fault_d = 1'b1;
          state_d = IDLE;
        end else if (stitch_done) begin
          frame_ready_d = 1'b1;
          if (!primed) begin
            prime_d = prime_q + 1'b1;
            slot_d  = next_slot(slot_q);
            state_d = WAIT_FRAME;
          end else begin
            state_d = READY;
          end
        end
      end
      READY: begin
        if (emit_req) begin
          emit_go_d = 1'b1;
          state_d   = WAIT_EMIT;
        end
      end
      WAIT_EMIT: begin
        if (wd_expired) begin
          fault_d = 1'b1;
          state_d = IDLE;
        end else if (emit_done) begin
          slot_d   = next_slot(slot_q);
          frames_d = frames_q + 1'b1;
          state_d  = WAIT_FRAME;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      prime_q       <= '0;
      frames_q      <= '0;
      under_q       <= '0;
      fault_q       <= 1'b0;
      stitch_go_q   <= 1'b0;
      emit_go_q     <= 1'b0;
      frame_ready_q <= 1'b0;
      emit_req_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      prime_q       <= prime_d;
      frames_q      <= frames_d;
      under_q       <= under_d;
      fault_q       <= fault_d;
      stitch_go_q   <= stitch_go_d;
      emit_go_q     <= emit_go_d;
      frame_ready_q <= frame_ready_d;
      emit_req_q    <= emit_req;
    end
  end

  // slot only moves on stitch_done (priming) or emit_done, so it is stable across each handshake.
  assign stitch_slot = slot_q;
  assign emit_slot   = slot_q;
  assign stitch_go   = stitch_go_q;
  assign emit_go     = emit_go_q;
  assign frame_ready = frame_ready_q;
  assign frames_out  = frames_q;
  assign underruns   = under_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_ola_window_scheduler.sv
// Scoreboard bench for ola_window_scheduler with behavioural iffter, stitcher and emitter.
module tb_ola_window_scheduler;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             frame_valid = 1'b0;
  logic             stitch_done = 1'b0;
  logic             emit_req = 1'b0;
  logic             emit_done = 1'b0;
  logic             frame_ready, stitch_go, emit_go, fault;
  logic [1:0]       stitch_slot, emit_slot;
  logic [CNT_W-1:0] frames_out, underruns;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] exp_stitch_q[$];
  logic [1:0] exp_emit_q[$];
  int         exp_ready = 0;
  bit         emit_out = 1'b0;

  always #5 clk = ~clk;

  ola_window_scheduler #(
    .NUM_SLOTS(4), .PRIME_WINDOWS(3), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .stitch_go(stitch_go), .stitch_slot(stitch_slot), .stitch_done(stitch_done),
    .emit_req(emit_req), .emit_go(emit_go), .emit_slot(emit_slot), .emit_done(emit_done),
    .frames_out(frames_out), .underruns(underruns), .fault(fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // which: 0 stitch_go, 1 emit_go, 2 frame_ready, 3 fault. Returns negedges waited, -1 on timeout.
  task automatic wait_pulse(input int which, input string name, output int cycles);
    bit seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < 200) begin
      @(negedge clk);
      cycles++;
      case (which)
        0:       seen = stitch_go;
        1:       seen = emit_go;
        2:       seen = frame_ready;
        default: seen = fault;
      endcase
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no pulse within 200 cycles", name);
      cycles = -1;
    end
  endtask

  task automatic iffter(input int n);
    int c;
    frame_valid = 1'b1;
    for (int i = 0; i < n; i++) wait_pulse(2, "frame_ready_wait", c);
    step();
    frame_valid = 1'b0;
  endtask

  task automatic stitcher(input int n, input int delay);
    int c;
    for (int i = 0; i < n; i++) begin
      wait_pulse(0, "stitch_go_wait", c);
      step(delay);
      stitch_done = 1'b1;
      step();
      stitch_done = 1'b0;
    end
  endtask

  task automatic emitter(input int n);
    int c;
    for (int i = 0; i < n; i++) begin
      wait_pulse(1, "emit_go_wait", c);
      step(3);
      emit_done = 1'b1;
      step();
      emit_done = 1'b0;
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues a pulse.
  always @(negedge clk) begin
    if (!reset_n) begin
      emit_out = 1'b0;
    end else begin
      if (emit_done) emit_out = 1'b0;
      if (stitch_go) begin
        check("stitch_after_emit_done", {31'd0, emit_out}, 32'd0);
        if (exp_stitch_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_stitch_go: got slot %0d, expected no pulse", stitch_slot);
        end else check("stitch_slot", {30'd0, stitch_slot}, {30'd0, exp_stitch_q.pop_front()});
      end
      if (emit_go) begin
        emit_out = 1'b1;
        if (exp_emit_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_emit_go: got slot %0d, expected no pulse", emit_slot);
        end else check("emit_slot", {30'd0, emit_slot}, {30'd0, exp_emit_q.pop_front()});
      end
      if (frame_ready) begin
        n_cmp++;
        if (exp_ready == 0) begin
          n_err++;
          $display("FAIL unexpected_frame_ready: got pulse, expected none");
        end else exp_ready--;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    // Reset values
    step(2);
    check("rst_flags", {28'd0, stitch_go, emit_go, frame_ready, fault}, 32'd0);
    check("rst_slots", {28'd0, stitch_slot, emit_slot}, 32'd0);
    check("rst_counters", {frames_out, underruns}, 32'd0);
    reset_n = 1'b1;
    step();

    // 1: priming windows at slots 0,1,2 then window at slot 3 reaches READY
    exp_stitch_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    exp_ready += 4;
    enable = 1'b1;
    fork
      iffter(4);
      stitcher(4, 5);
    join
    frame_valid = 1'b1;
    step(10);
    frame_valid = 1'b0;
    check("prime_frames_out", frames_out, 0);

    // 2: steady state, emit_req held, 8 quarters out
    exp_stitch_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    exp_emit_q   = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    exp_ready += 7;
    fork
      iffter(7);
      stitcher(7, 5);
      emitter(8);
      begin
        emit_req = 1'b1;
        @(negedge clk);
        check("emit_latency_c0", {31'd0, emit_go}, 32'd0);
        @(negedge clk);
        check("emit_latency_c1", {31'd0, emit_go}, 32'd1);
      end
    join
    emit_req = 1'b0;
    step();
    check("steady_frames_out", frames_out, 8);
    check("steady_underruns", underruns, 0);

    // 3: emit_req pulses while stitcher busy count as underruns
    exp_stitch_q.push_back(2'd3);
    exp_ready += 1;
    fork
      iffter(1);
      stitcher(1, 10);
      begin
        @(negedge clk);
        check("stitch_latency_c0", {31'd0, stitch_go}, 32'd0);
        @(negedge clk);
        check("stitch_latency_c1", {31'd0, stitch_go}, 32'd1);
        repeat (3) begin
          step();
          emit_req = 1'b1;
          step();
          emit_req = 1'b0;
        end
      end
    join
    check("underruns_busy", underruns, 3);
    exp_emit_q.push_back(2'd3);
    emit_req = 1'b1;
    emitter(1);
    emit_req = 1'b0;
    step();
    check("underruns_ready", underruns, 3);
    check("frames_out_9", frames_out, 9);

    // 4: stitch_done withheld -> fault after TIMEOUT cycles, sticky
    exp_stitch_q.push_back(2'd0);
    frame_valid = 1'b1;
    wait_pulse(0, "timeout_stitch_go", lat);
    wait_pulse(3, "fault_wait", lat);
    check("fault_latency", lat, TIMEOUT);
    enable = 1'b0;
    step(2);
    enable = 1'b1;
    step(10);
    check("fault_sticky", {31'd0, fault}, 32'd1);
    check("fault_frames_out", frames_out, 9);
    frame_valid = 1'b0;
    enable = 1'b0;
    reset_n = 1'b0;
    #1;
    check("fault_cleared", {31'd0, fault}, 32'd0);
    check("reset_counters", {frames_out, underruns}, 32'd0);
    step(2);
    reset_n = 1'b1;

    // 5: drop enable mid-stitch, window completes, resume at next slot
    enable = 1'b1;
    step();
    exp_stitch_q.push_back(2'd0);
    exp_ready += 1;
    fork
      iffter(1);
      stitcher(1, 5);
      begin
        wait_pulse(0, "disable_stitch_go", lat);
        step();
        enable = 1'b0;
      end
    join
    step(2);
    frame_valid = 1'b1;
    step(8);
    exp_stitch_q.push_back(2'd1);
    exp_ready += 1;
    enable = 1'b1;
    fork
      iffter(1);
      stitcher(1, 5);
    join

    // 6: reset during WAIT_EMIT truncates emit_go and restarts from slot 0
    exp_stitch_q.push_back(2'd2);
    exp_stitch_q.push_back(2'd3);
    exp_ready += 2;
    fork
      iffter(2);
      stitcher(2, 5);
    join
    exp_emit_q.push_back(2'd3);
    emit_req = 1'b1;
    wait_pulse(1, "reset_emit_go", lat);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_emit_go", {31'd0, emit_go}, 32'd0);
    check("reset_slots", {28'd0, stitch_slot, emit_slot}, 32'd0);
    emit_req = 1'b0;
    step(2);
    reset_n = 1'b1;
    step();
    exp_stitch_q.push_back(2'd0);
    exp_ready += 1;
    fork
      iffter(1);
      stitcher(1, 5);
    join
    step(3);

    check("stitch_queue_empty", exp_stitch_q.size(), 0);
    check("emit_queue_empty", exp_emit_q.size(), 0);
    check("ready_pending", exp_ready, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
